sticker_scanner: RTL and testbench

STICKER_SCANNER -- requirements
Module: sticker_scanner

---
 rtl/sticker_scanner.sv | 131 +++++++++++++
 tb/tb_sticker_scanner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sticker_scanner.sv
// Sticker colour scanner: walks every corner/edge sticker, requests setup moves,
// debounces the sensor code over SAMPLES cycles and assembles the cube state word.
module sticker_scanner #(
  parameter int COLOR_W    = 3,
  parameter int NUM_CORNER = 24,
  parameter int NUM_EDGE   = 24,
  parameter int NUM_COLORS = 6,
  parameter int SAMPLES    = 3,
  parameter int MAX_RETRY  = 4,
  parameter logic [6*COLOR_W-1:0] CENTERS = {COLOR_W'(5), COLOR_W'(4), COLOR_W'(3),
                                             COLOR_W'(2), COLOR_W'(1), COLOR_W'(0)}
) (
  input  logic                                         clock,
  input  logic                                         reset_n,
  input  logic                                         start,
  input  logic [COLOR_W-1:0]                           corner_color,
  input  logic [COLOR_W-1:0]                           edge_color,
  input  logic                                         moves_done,
  input  logic                                         sensor_stable,
  output logic                                         setup_req,
  output logic [7:0]                                   setup_idx,
  output logic [(NUM_CORNER+NUM_EDGE+6)*COLOR_W-1:0]   cubestate,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         error,
  output logic [2:0]                                   dbg_state
);
  localparam int N = NUM_CORNER + NUM_EDGE;
  localparam logic [7:0]       FIRST_EDGE = 8'(NUM_CORNER);
  localparam logic [7:0]       LAST_IDX   = 8'(N - 1);
  localparam logic [COLOR_W:0] NC_LIMIT   = (COLOR_W+1)'(NUM_COLORS);
  localparam logic [3:0]       LAST_SAMP  = 4'(SAMPLES - 1);
  localparam logic [3:0]       LAST_RETRY = 4'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_MOVE, S_WAIT_STABLE, S_SAMPLE, S_COMMIT, S_DONE, S_ERR
  } state_t;

  state_t                 state;
  logic [N*COLOR_W-1:0]   stickers;
  logic [COLOR_W-1:0]     ref_color;
  logic [3:0]             sample_cnt;
  logic [3:0]             retry_cnt;
  logic [COLOR_W-1:0]     sel_color;
  logic                   sel_valid;
  logic                   sample_ok;

  assign sel_color = (setup_idx < FIRST_EDGE) ? corner_color : edge_color;
  assign sel_valid = ({1'b0, sel_color} < NC_LIMIT);
  // The first sample of a window only has to be valid; it becomes the reference.
  assign sample_ok = sel_valid && ((sample_cnt == 4'd0) || (sel_color == ref_color));

  assign cubestate = {CENTERS, stickers};
  assign dbg_state = state;

  // Handshake: setup_req is a one-cycle pulse (the REQ cycle); the mover answers
  // with a one-cycle moves_done pulse, honoured only while waiting in WAIT_MOVE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      stickers   <= '0;
      ref_color  <= '0;
      sample_cnt <= '0;
      retry_cnt  <= '0;
      setup_idx  <= '0;
      setup_req  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      setup_req <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            stickers   <= '0;
            setup_idx  <= '0;
            retry_cnt  <= '0;
            sample_cnt <= '0;
            setup_req  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            state      <= S_REQ;
          end
        end
        S_REQ: state <= S_WAIT_MOVE;
        S_WAIT_MOVE: begin
          if (moves_done) state <= S_WAIT_STABLE;
        end
        S_WAIT_STABLE: begin
          if (sensor_stable) begin
            sample_cnt <= '0;
            state      <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (!sensor_stable) begin
            state <= S_WAIT_STABLE;
          end else if (sample_ok) begin
            if (sample_cnt == 4'd0) ref_color <= sel_color;
            if (sample_cnt == LAST_SAMP) state <= S_COMMIT;
            else sample_cnt <= sample_cnt + 4'd1;
          end else begin
            retry_cnt <= retry_cnt + 4'd1;
            if (retry_cnt == LAST_RETRY) begin
              busy  <= 1'b0;
              error <= 1'b1;
              state <= S_ERR;
            end else begin
              state <= S_WAIT_STABLE;
            end
          end
        end
        S_COMMIT: begin
          stickers[int'(setup_idx)*COLOR_W +: COLOR_W] <= ref_color;
          retry_cnt <= '0;
          if (setup_idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            setup_idx <= setup_idx + 8'd1;
            setup_req <= 1'b1;
            state     <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sticker_scanner.sv
// Bench for sticker_scanner: plays the cube robot (moves, sensors) from per-sticker
// scenarios and checks the final cube state against scenario-derived expectations.
module tb_sticker_scanner;
  localparam int W  = 3;
  localparam int NC = 24;
  localparam int NE = 24;
  localparam int N  = NC + NE;
  localparam int SAMP = 3;
  localparam int BUDGET = 8000;

  logic                 clock;
  logic                 reset_n;
  logic                 start;
  logic [W-1:0]         corner_color;
  logic [W-1:0]         edge_color;
  logic                 moves_done;
  logic                 sensor_stable;
  logic                 setup_req;
  logic [7:0]           setup_idx;
  logic [(N+6)*W-1:0]   cubestate;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [2:0]           dbg_state;

  sticker_scanner dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .corner_color(corner_color), .edge_color(edge_color),
    .moves_done(moves_done), .sensor_stable(sensor_stable),
    .setup_req(setup_req), .setup_idx(setup_idx), .cubestate(cubestate),
    .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // scenario: per-sticker true colour, length of the disturbed stretch, kind
  // (0 = invalid codes, 1 = toggling against a neighbour colour), failing sticker
  int exp_col [N];
  int bad_len [N];
  int bad_kind[N];
  int err_k;

  int n_req, min_gap, max_gap;
  bit got_end, ended_reset;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_color(input int k, input int since, input int cyc);
    logic [W-1:0] v;
    logic [W-1:0] junk;
    junk = W'($urandom_range(7, 0));
    if (k < 0) begin
      v = W'($urandom_range(7, 0));
    end else if (k == err_k || (bad_len[k] > 0 && since <= bad_len[k])) begin
      if (bad_kind[k] == 0) v = W'($urandom_range(7, 6));
      else v = (cyc % 2 == 1) ? W'(exp_col[k]) : W'((exp_col[k] + 1) % 6);
    end else begin
      v = W'(exp_col[k]);
    end
    if (k >= 0 && k < NC) begin
      corner_color = v;
      edge_color   = junk;
    end else begin
      edge_color   = v;
      corner_color = junk;
    end
  endtask

  // driver: issue start, then answer setup requests and feed the sensors
  task automatic run_scan(input int dmin, input int dmax, input int stable_pct,
                          input int reset_at, input int busy_start_at);
    int cur, md_wait, since, last_req;
    bit moved;
    cur = -1; md_wait = 0; since = 0; last_req = -1; moved = 0;
    n_req = 0; min_gap = 1000000; max_gap = 0; got_end = 0; ended_reset = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_done", done, 0);
    check_eq("start_error", error, 0);
    check_eq("start_cleared", (cubestate[N*W-1:0] == '0), 1);
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      if (done || error) begin
        got_end = 1;
        break;
      end
      if (setup_req) begin
        cur++;
        n_req++;
        check_eq("setup_idx", setup_idx, cur);
        if (last_req >= 0) begin
          if (cyc - last_req < min_gap) min_gap = cyc - last_req;
          if (cyc - last_req > max_gap) max_gap = cyc - last_req;
        end
        last_req = cyc;
        md_wait  = $urandom_range(dmax, dmin);
        since    = 0;
        moved    = 0;
        if (cur == busy_start_at) start = 1'b1;
        if (cur == reset_at) begin
          #2 reset_n = 1'b0;
          #1;
          check_eq("rst_setup_req", setup_req, 0);
          check_eq("rst_idx", setup_idx, 0);
          check_eq("rst_busy", busy, 0);
          check_eq("rst_done_err", {done, error}, 0);
          check_eq("rst_fields", (cubestate[N*W-1:0] == '0), 1);
          @(negedge clock);
          reset_n = 1'b1;
          ended_reset = 1;
          return;
        end
      end else if (md_wait > 0) begin
        md_wait--;
        if (md_wait == 0) begin
          moves_done = 1'b1;
          moved = 1;
        end
      end
      if (moved) since++;
      drive_color(cur, since, cyc);
      sensor_stable = ($urandom_range(99, 0) < stable_pct);
      @(negedge clock);
      moves_done = 1'b0;
      start = 1'b0;
    end
    check_eq("scan_finished", got_end, 1);
  endtask

  // scoreboard: expected fields and status derived from the scenario
  task automatic check_scan();
    bit fail_run;
    fail_run = (err_k >= 0);
    check_eq("end_done", done, !fail_run);
    check_eq("end_error", error, fail_run);
    check_eq("end_busy", busy, 0);
    check_eq("end_idx", setup_idx, fail_run ? err_k : N - 1);
    check_eq("req_pulses", n_req, fail_run ? err_k + 1 : N);
    for (int k = 0; k < N; k++)
      exp_q.push_back((fail_run && k >= err_k) ? W'(0) : W'(exp_col[k]));
    for (int k = 0; k < N; k++)
      check_eq($sformatf("field%0d", k), cubestate[k*W +: W], exp_q.pop_front());
    for (int j = 0; j < 6; j++)
      check_eq($sformatf("center%0d", j), cubestate[(N+j)*W +: W], j);
  endtask

  task automatic clean_scenario();
    for (int k = 0; k < N; k++) begin
      exp_col[k] = k % 6; bad_len[k] = 0; bad_kind[k] = 0;
    end
    err_k = -1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; moves_done = 1'b0; sensor_stable = 1'b1;
    corner_color = '0; edge_color = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("reset_status", {setup_req, busy, done, error}, 0);
    check_eq("reset_idx", setup_idx, 0);
    check_eq("reset_fields", (cubestate[N*W-1:0] == '0), 1);
    check_eq("reset_centers", cubestate[(N+6)*W-1 -: 6*W], 18'o543210);

    // moves_done while idle must not start anything
    moves_done = 1'b1;
    repeat (3) @(negedge clock);
    moves_done = 1'b0;
    check_eq("idle_moves_ignored", {setup_req, busy}, 0);

    // clean full scan at minimum latency, with a start pulse while busy
    clean_scenario();
    run_scan(1, 1, 100, -1, 10);
    check_scan();
    check_eq("min_gap", min_gap, 4 + SAMP);
    check_eq("max_gap", max_gap, 4 + SAMP);

    // restart from DONE; sticker 30 sees one invalid code before settling on 4
    clean_scenario();
    for (int k = 0; k < N; k++) exp_col[k] = $urandom_range(5, 0);
    exp_col[30] = 4; bad_len[30] = 3; bad_kind[30] = 0;
    run_scan(2, 2, 100, -1, -1);
    check_scan();

    // sticker 5 toggles 2/3 forever: scan must stop in error at index 5
    clean_scenario();
    exp_col[5] = 2; bad_kind[5] = 1; err_k = 5;
    run_scan(1, 3, 100, -1, -1);
    check_scan();

    // asynchronous reset in the middle of sticker 20, then rescan from 0
    clean_scenario();
    run_scan(1, 2, 100, 20, -1);
    check_eq("reset_taken", ended_reset, 1);
    run_scan(1, 3, 100, -1, -1);
    check_scan();

    // randomized scenarios with sensor drop-outs and disturbed windows
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < N; k++) begin
        exp_col[k]  = $urandom_range(5, 0);
        bad_len[k]  = ($urandom_range(9, 0) < 4) ? $urandom_range(3, 1) : 0;
        bad_kind[k] = $urandom_range(1, 0);
      end
      err_k = ($urandom_range(9, 0) < 3) ? $urandom_range(N - 1, 0) : -1;
      run_scan(1, 3, 75, -1, ($urandom_range(1, 0) == 1) ? $urandom_range(N - 1, 0) : -1);
      check_scan();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
